apb_xfer_ctrl: RTL and testbench

//   Downstream of start_gen. Consumes its one-cycle start pulse and rw flag and runs a single
//   APB master transfer (SETUP -> ACCESS -> wait pready) on the peripheral bus.

---
 rtl/apb_xfer_ctrl.sv | 125 ++++++++++++
 tb/tb_apb_xfer_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/apb_xfer_ctrl.sv
// APB master transfer controller: one SETUP/ACCESS transfer per start pulse,
// with registered bus outputs, read-data capture and a pready timeout.
module apb_xfer_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              ovr
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] paddr_n;
    logic              pwrite_n;
    logic [DATA_W-1:0] pwdata_n;
    logic [DATA_W-1:0] rdata_n;
    logic              done_n, err_n, ovr_n;
    logic              psel_n, penable_n;
    logic [CW-1:0]     cnt, cnt_n, cnt_inc;

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            rdata   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            ovr     <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            paddr   <= paddr_n;
            pwrite  <= pwrite_n;
            pwdata  <= pwdata_n;
            psel    <= psel_n;
            penable <= penable_n;
            rdata   <= rdata_n;
            done    <= done_n;
            err     <= err_n;
            busy    <= psel_n;
            ovr     <= ovr_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        paddr_n  = paddr;
        pwrite_n = pwrite;
        pwdata_n = pwdata;
        rdata_n  = rdata;
        done_n   = 1'b0;
        err_n    = 1'b0;
        ovr_n    = 1'b0;
        cnt_n    = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    paddr_n  = addr;
                    pwrite_n = rw;
                    pwdata_n = wdata;
                    cnt_n    = '0;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                ovr_n   = start;
                state_n = ACCESS;
            end
            ACCESS: begin
                ovr_n = start;
                if (pready) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    err_n   = pslverr;
                    if (!pwrite) rdata_n = prdata;
                end else if (TIMEOUT != 0 && cnt_inc == TMAX) begin
                    // dead slave: abort, leave rdata untouched
                    state_n = IDLE;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: state_n = IDLE;
        endcase
        psel_n    = (state_n != IDLE);
        penable_n = (state_n == ACCESS);
    end

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Self-checking bench for apb_xfer_ctrl: directed cases plus randomized
// transfers checked against a per-transfer timing/result model.
module tb_apb_xfer_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, rw;
    logic [7:0]  addr, paddr;
    logic [31:0] wdata, pwdata, prdata, rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic        done, err, busy, ovr;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_rdata = '0;

    apb_xfer_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr),
        .wdata(wdata), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .rdata(rdata), .done(done), .err(err),
        .busy(busy), .ovr(ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer starting now; leaves the bench in the done cycle.
    // waits = ACCESS cycles with pready low; ovr_at = edge index (0 = SETUP
    // edge) at which a stray start is pulsed, -1 for none.
    task automatic xfer(input bit wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [31:0] pd,
                        input int waits, input bit se, input int ovr_at);
        bit to;
        int acc;
        int oa;
        to  = (TO != 0) && (waits >= TO);
        acc = to ? TO : waits + 1;
        oa  = (ovr_at > acc) ? acc : ovr_at;
        start = 1'b1; rw = wr; addr = a; wdata = wd;
        pready = 1'b0; pslverr = 1'b0;
        step();
        start = 1'b0; rw = ~wr; addr = ~a; wdata = ~wd;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_busy", busy, 1);
        chk("setup_done", done, 0);
        chk("setup_err", err, 0);
        chk("paddr", paddr, a);
        chk("pwrite", pwrite, wr);
        chk("pwdata", pwdata, wd);
        for (int k = 0; k <= acc; k++) begin
            if (k == acc && !to) begin
                pready = 1'b1; pslverr = se; prdata = pd;
            end else begin
                pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
            end
            start = (k == oa);
            if (k == oa) begin
                addr = $urandom; rw = 1'($urandom); wdata = $urandom;
            end
            step();
            start = 1'b0; pready = 1'b0; pslverr = 1'b0;
            chk("ovr", ovr, (k == oa));
            if (k < acc) begin
                chk("acc_psel", psel, 1);
                chk("acc_penable", penable, 1);
                chk("acc_done", done, 0);
                chk("acc_paddr", paddr, a);
                chk("acc_pwdata", pwdata, wd);
            end
        end
        if (!wr && !to) m_rdata = pd;
        chk("done", done, 1);
        chk("err", err, (to || se));
        chk("end_psel", psel, 0);
        chk("end_penable", penable, 0);
        chk("end_busy", busy, 0);
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic idle_chk();
        step();
        chk("idle_done", done, 0);
        chk("idle_err", err, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ovr", ovr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #23;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_paddr", paddr, 0);
        step();
        rst = 1'b0;
        idle_chk();

        // zero-wait write
        xfer(1'b1, 8'h10, 32'hA5A5_0001, 32'h0, 0, 1'b0, -1);
        idle_chk();
        // read with 3 waits
        xfer(1'b0, 8'h24, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, -1);
        idle_chk();
        // timeout keeps old rdata
        xfer(1'b0, 8'h31, 32'h0, 32'h1234_5678, TO + 3, 1'b0, -1);
        idle_chk();
        // slave error write, next start in the done cycle
        xfer(1'b1, 8'h40, 32'h0BAD_0BAD, 32'h0, 0, 1'b1, -1);
        xfer(1'b0, 8'h41, 32'h0, 32'hCAFE_F00D, 1, 1'b0, -1);
        idle_chk();
        // stray start during ACCESS of a read
        xfer(1'b0, 8'h55, 32'h0, 32'h0F0F_0F0F, 2, 1'b0, 2);
        idle_chk();
        // reset mid-transfer
        start = 1'b1; rw = 1'b1; addr = 8'h66; wdata = 32'h7777_7777;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mrst_psel", psel, 0);
        chk("mrst_penable", penable, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        m_rdata = '0;
        step();
        rst = 1'b0;
        idle_chk();
        xfer(1'b1, 8'h77, 32'h1357_9BDF, 32'h0, 1, 1'b0, -1);
        idle_chk();

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), 8'($urandom), $urandom, $urandom,
                 $urandom_range(0, TO + 2), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8) : -1);
            if ($urandom_range(0, 1) == 1) idle_chk();
        end
        idle_chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
